bus_read_seq: RTL and testbench

- Read-side counterpart of the datapath register file. Registers are written from the shared bus under load_enable.
- This block sequences their stored outputs back onto the shared bus as a burst of one or more words, using a valid/ready handshake.
- It replaces the free-running output multiplexer with a controlled reader. The reader snapshots each register word and holds it stable until the consumer (ALU or core bus master) accepts it.

---
 rtl/bus_read_seq.sv | 156 +++++++++++++++
 tb/tb_bus_read_seq.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/bus_read_seq.sv
// Burst reader that snapshots register-file words onto a shared bus with a valid/ready handshake.
// Optional macro BUS_READ_PARITY_EN adds a bus_parity output tracking the parity of bus_data.
module bus_read_seq #(
    parameter int NUM_REGS = 8,
    parameter int SEL_W    = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REGS*16-1:0] reg_data_flat,
    input  logic                   rd_start,
    input  logic [SEL_W-1:0]       rd_base,
    input  logic [SEL_W:0]         rd_len,
    input  logic                   bus_ready,
    output logic [15:0]            bus_data,
    output logic                   bus_valid,
    output logic [SEL_W-1:0]       bus_sel,
    output logic                   busy,
    output logic                   done,
`ifdef BUS_READ_PARITY_EN
    output logic                   bus_parity,
`endif
    output logic                   err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int                 NUM_SLOTS = 2 ** SEL_W;
    localparam logic [SEL_W:0]     LEN_MAX   = (SEL_W + 1)'(NUM_REGS);
    localparam logic [SEL_W-1:0]   LAST_IDX  = SEL_W'(NUM_REGS - 1);

    state_t             state_reg, state_next;
    logic [SEL_W:0]     remaining_reg, remaining_next;
    logic [15:0]        data_reg, data_next;
    logic [SEL_W-1:0]   sel_reg, sel_next;
    logic               valid_reg, valid_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;
    logic               err_reg, err_next;
    logic [SEL_W-1:0]   next_idx;
    logic               len_ok;

    // Unpack the flat bus; slots beyond NUM_REGS read as zero so any index is safe.
    logic [15:0] reg_words [NUM_SLOTS];

    generate
        for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_unpack
            if (gi < NUM_REGS) begin : g_real
                assign reg_words[gi] = reg_data_flat[16*gi +: 16];
            end else begin : g_pad
                assign reg_words[gi] = 16'h0000;
            end
        end
    endgenerate

    // Explicit wrap so non-power-of-two register counts step from NUM_REGS-1 back to 0.
    assign next_idx = (sel_reg == LAST_IDX) ? '0 : sel_reg + 1'b1;
    assign len_ok   = (rd_len != '0) && (rd_len <= LEN_MAX);

    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        data_next      = data_reg;
        sel_next       = sel_reg;
        valid_next     = valid_reg;
        busy_next      = busy_reg;
        done_next      = 1'b0;
        err_next       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (rd_start) begin
                    if (len_ok) begin
                        remaining_next = rd_len;
                        sel_next       = rd_base;
                        data_next      = reg_words[rd_base];
                        valid_next     = 1'b1;
                        busy_next      = 1'b1;
                        state_next     = DRIVE;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            DRIVE: begin
                if (valid_reg && bus_ready) begin
                    if (remaining_reg > 1) begin
                        sel_next       = next_idx;
                        data_next      = reg_words[next_idx];
                        remaining_next = remaining_reg - 1'b1;
                    end else begin
                        // Last word accepted: drop valid but keep the word on the bus.
                        valid_next = 1'b0;
                        done_next  = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= IDLE;
            remaining_reg <= '0;
            data_reg      <= 16'h0000;
            sel_reg       <= '0;
            valid_reg     <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            remaining_reg <= remaining_next;
            data_reg      <= data_next;
            sel_reg       <= sel_next;
            valid_reg     <= valid_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
        end
    end

`ifdef BUS_READ_PARITY_EN
    logic parity_reg;

    // Parity follows data_next, so it is loaded and held exactly alongside bus_data.
    always_ff @(posedge clk) begin
        if (!reset) begin
            parity_reg <= 1'b0;
        end else begin
            parity_reg <= ^data_next;
        end
    end

    assign bus_parity = parity_reg;
`endif

    assign bus_data  = data_reg;
    assign bus_valid = valid_reg;
    assign bus_sel   = sel_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_bus_read_seq.sv
// Directed bench for bus_read_seq: bursts, stalls with wrap, illegal lengths, mid-burst reset.
module tb_bus_read_seq;

    localparam int NUM_REGS = 8;
    localparam int SEL_W    = 3;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NUM_REGS*16-1:0] reg_data_flat;
    logic                   rd_start;
    logic [SEL_W-1:0]       rd_base;
    logic [SEL_W:0]         rd_len;
    logic                   bus_ready;
    logic [15:0]            bus_data;
    logic                   bus_valid;
    logic [SEL_W-1:0]       bus_sel;
    logic                   busy;
    logic                   done;
    logic                   err;
`ifdef BUS_READ_PARITY_EN
    logic                   bus_parity;
`endif

    logic [15:0] regs [NUM_REGS];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    always_comb begin
        reg_data_flat = '0;
        for (int i = 0; i < NUM_REGS; i++) reg_data_flat[16*i +: 16] = regs[i];
    end

    bus_read_seq #(.NUM_REGS(NUM_REGS), .SEL_W(SEL_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .reg_data_flat (reg_data_flat),
        .rd_start      (rd_start),
        .rd_base       (rd_base),
        .rd_len        (rd_len),
        .bus_ready     (bus_ready),
        .bus_data      (bus_data),
        .bus_valid     (bus_valid),
        .bus_sel       (bus_sel),
        .busy          (busy),
        .done          (done),
`ifdef BUS_READ_PARITY_EN
        .bus_parity    (bus_parity),
`endif
        .err           (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [15:0] d, input logic [2:0] s,
                            input logic v, input logic b, input logic dn, input logic e);
        chk({tag, ".data"},  32'(bus_data),  32'(d));
        chk({tag, ".sel"},   32'(bus_sel),   32'(s));
        chk({tag, ".valid"}, 32'(bus_valid), 32'(v));
        chk({tag, ".busy"},  32'(busy),      32'(b));
        chk({tag, ".done"},  32'(done),      32'(dn));
        chk({tag, ".err"},   32'(err),       32'(e));
        $display("t=%0t %s data=%h sel=%0d valid=%b busy=%b done=%b err=%b",
                 $time, tag, bus_data, bus_sel, bus_valid, busy, done, err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Stall scenario: ready pattern and expected bus state after each edge.
    logic        stall_rdy  [7] = '{1, 0, 0, 1, 1, 0, 1};
    logic [15:0] stall_data [7] = '{16'h1007, 16'h1007, 16'h1007, 16'h1000, 16'h1001, 16'h1001, 16'h1001};
    logic [2:0]  stall_sel  [7] = '{7, 7, 7, 0, 1, 1, 1};
    logic        stall_vld  [7] = '{1, 1, 1, 1, 1, 1, 0};
    logic        stall_done [7] = '{0, 0, 0, 0, 0, 0, 1};

    initial begin
        for (int i = 0; i < NUM_REGS; i++) regs[i] = 16'h1000 + 16'(i);
        reset = 1'b0; rd_start = 1'b0; rd_base = '0; rd_len = '0; bus_ready = 1'b0;
        tick(); tick();
        chk_word("reset", 16'h0000, 3'd0, 0, 0, 0, 0);
`ifdef BUS_READ_PARITY_EN
        chk("reset.parity", 32'(bus_parity), 32'd0);
`endif
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle.valid", 32'(bus_valid), 32'd0);
        end

        // Burst base=2 len=3, ready held high.
        rd_base = 3'd2; rd_len = 4'd3; rd_start = 1'b1; bus_ready = 1'b1;
        tick(); rd_start = 1'b0;
        chk_word("b1.w0", 16'h1002, 3'd2, 1, 1, 0, 0);
        tick(); chk_word("b1.w1", 16'h1003, 3'd3, 1, 1, 0, 0);
        tick(); chk_word("b1.w2", 16'h1004, 3'd4, 1, 1, 0, 0);
        tick(); chk_word("b1.done", 16'h1004, 3'd4, 0, 1, 1, 0);
        // A start during DONE must be ignored.
        rd_base = 3'd0; rd_len = 4'd2; rd_start = 1'b1;
        tick(); rd_start = 1'b0;
        chk_word("b1.idle", 16'h1004, 3'd4, 0, 0, 0, 0);
        tick(); chk_word("b1.quiet", 16'h1004, 3'd4, 0, 0, 0, 0);

        // Burst base=6 len=4 with stalls and wrap.
        rd_base = 3'd6; rd_len = 4'd4; rd_start = 1'b1; bus_ready = 1'b0;
        tick(); rd_start = 1'b0;
        chk_word("b2.w0", 16'h1006, 3'd6, 1, 1, 0, 0);
        for (int i = 0; i < 7; i++) begin
            bus_ready = stall_rdy[i];
            if (i == 1) begin
                regs[7] = 16'hBEEF;
                rd_start = 1'b1; rd_len = 4'd0; rd_base = 3'd3;
            end
            tick();
            rd_start = 1'b0;
            chk_word($sformatf("b2.s%0d", i), stall_data[i], stall_sel[i], stall_vld[i], 1,
                     stall_done[i], 0);
        end
        bus_ready = 1'b0; regs[7] = 16'h1007;
        tick(); chk_word("b2.idle", 16'h1001, 3'd1, 0, 0, 0, 0);

        // Illegal lengths.
        rd_base = 3'd1; rd_len = 4'd0; rd_start = 1'b1;
        tick(); rd_start = 1'b0;
        chk_word("err0", 16'h1001, 3'd1, 0, 0, 0, 1);
        tick(); chk_word("err0.clr", 16'h1001, 3'd1, 0, 0, 0, 0);
        rd_len = 4'd9; rd_start = 1'b1;
        tick(); rd_start = 1'b0;
        chk_word("err9", 16'h1001, 3'd1, 0, 0, 0, 1);
        tick(); chk_word("err9.clr", 16'h1001, 3'd1, 0, 0, 0, 0);

        // Mid-burst reset after three accepted words.
        rd_base = 3'd0; rd_len = 4'd8; rd_start = 1'b1; bus_ready = 1'b1;
        tick(); rd_start = 1'b0;
        chk_word("b3.w0", 16'h1000, 3'd0, 1, 1, 0, 0);
        tick(); tick(); tick();
        chk_word("b3.w3", 16'h1003, 3'd3, 1, 1, 0, 0);
        reset = 1'b0;
        tick();
        chk_word("b3.rst", 16'h0000, 3'd0, 0, 0, 0, 0);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("b3.nodone", 32'(done), 32'd0);
        end
        rd_base = 3'd5; rd_len = 4'd2; rd_start = 1'b1;
        tick(); rd_start = 1'b0;
        chk_word("b4.w0", 16'h1005, 3'd5, 1, 1, 0, 0);
        tick(); chk_word("b4.w1", 16'h1006, 3'd6, 1, 1, 0, 0);
        tick(); chk_word("b4.done", 16'h1006, 3'd6, 0, 1, 1, 0);
        tick(); chk_word("b4.idle", 16'h1006, 3'd6, 0, 0, 0, 0);

`ifdef BUS_READ_PARITY_EN
        regs[0] = 16'h0007; regs[1] = 16'h0003;
        rd_base = 3'd0; rd_len = 4'd2; rd_start = 1'b1; bus_ready = 1'b1;
        tick(); rd_start = 1'b0;
        chk("par.w0.data", 32'(bus_data), 32'h0007);
        chk("par.w0", 32'(bus_parity), 32'd1);
        tick();
        chk("par.w1.data", 32'(bus_data), 32'h0003);
        chk("par.w1", 32'(bus_parity), 32'd0);
        tick(); tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
